// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI master controller slice.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TRAIL,
    S_DONE
  } spi_state_t;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_CLK_DIV = 2;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: pulses o_phase_tick on the last cycle of each
// CLK_DIV-cycle phase while enabled; o_first marks the first cycle of a phase.
module spi_clk_div
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic CLK,
  input  logic CLR,
  input  logic i_en,
  input  logic i_clear,
  output logic o_phase_tick,
  output logic o_first
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_phase_tick = i_en && (r_cnt == CNT_LAST);
  assign o_first      = (r_cnt == '0);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_phase_tick) r_cnt <= '0;
      else              r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master transfer controller: FSM, shift registers, bit counter.
// Define SPI_LSB_FIRST_EN for LSB-first shifting (default build is MSB first).
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              CS_N,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  spi_state_t r_state, w_state_nxt;

  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_tx_sr, r_rx_sr, r_rx_data;
  logic [DATA_W-1:0] w_tx_shifted, w_rx_shifted;
  logic r_sclk, r_cs_n, r_busy, r_done;
  logic w_accept, w_div_en, w_tick, w_first, w_active;
  logic w_capture, w_shift, w_bit_inc, w_sclk_nxt, w_miso, w_busy_nxt;

  // Anything other than a clean 1 on MISO is taken as 0.
  assign w_miso   = (MISO === 1'b1);
  assign w_active = (r_sclk != SPI_CPOL);
  assign w_div_en = (r_state == S_LEAD) || (r_state == S_XFER) || (r_state == S_TRAIL);

`ifdef SPI_LSB_FIRST_EN
  assign w_tx_shifted = {1'b0, r_tx_sr[DATA_W-1:1]};
  assign w_rx_shifted = {w_miso, r_rx_sr[DATA_W-1:1]};
  assign MOSI         = r_tx_sr[0];
`else
  assign w_tx_shifted = {r_tx_sr[DATA_W-2:0], 1'b0};
  assign w_rx_shifted = {r_rx_sr[DATA_W-2:0], w_miso};
  assign MOSI         = r_tx_sr[DATA_W-1];
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .CLK         (CLK),
    .CLR         (CLR),
    .i_en        (w_div_en),
    .i_clear     (w_accept),
    .o_phase_tick(w_tick),
    .o_first     (w_first)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_bit_inc   = 1'b0;
    w_sclk_nxt  = SPI_CPOL;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LEAD;
        end
      end
      S_LEAD: begin
        if (w_tick) begin
          w_state_nxt = S_XFER;
          w_sclk_nxt  = ~SPI_CPOL;
        end
      end
      S_XFER: begin
        w_sclk_nxt = r_sclk;
        w_capture  = w_first && (w_active != SPI_CPHA);
        if (w_tick) begin
          if (w_active) begin
            w_sclk_nxt = ~r_sclk;
            w_shift    = 1'b1;
          end else if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = S_TRAIL;
          end else begin
            w_sclk_nxt = ~r_sclk;
            w_bit_inc  = 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (w_tick) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == S_LEAD) || (w_state_nxt == S_XFER) ||
                      (w_state_nxt == S_TRAIL);

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_sclk    <= SPI_CPOL;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
    end else begin
      r_sclk <= w_sclk_nxt;
      r_busy <= w_busy_nxt;
      r_cs_n <= !w_busy_nxt;
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_tx_sr   <= tx_data;
        r_rx_sr   <= '0;
        r_bit_cnt <= '0;
      end else begin
        if (w_shift)   r_tx_sr   <= w_tx_shifted;
        if (w_capture) r_rx_sr   <= w_rx_shifted;
        if (w_bit_inc) r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_state_nxt == S_DONE) r_rx_data <= r_rx_sr;
    end
  end

  assign SCLK    = r_sclk;
  assign CS_N    = r_cs_n;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (default 8/2 instance and a 4/1 instance).
// Expectations follow SPI_LSB_FIRST_EN the same way the RTL build does.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       start, start4;
  logic [7:0] tx_data, rx_data;
  logic [3:0] tx4, rx4;
  logic       busy, done, cs_n, sclk, mosi;
  logic       busy4, done4, cs_n4, sclk4, mosi4;
  logic [1:0] miso_mode;
  wire        miso;
  wire        miso4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign miso  = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? 1'b1 : 1'bz;
  assign miso4 = mosi4;

  spi_master_ctrl u_dut (
    .CLK(clk), .CLR(clr), .start(start), .tx_data(tx_data), .busy(busy),
    .done(done), .rx_data(rx_data), .CS_N(cs_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
  );

  spi_master_ctrl #(.DATA_W(4), .CLK_DIV(1)) u_dut4 (
    .CLK(clk), .CLR(clr), .start(start4), .tx_data(tx4), .busy(busy4),
    .done(done4), .rx_data(rx4), .CS_N(cs_n4), .SCLK(sclk4), .MOSI(mosi4), .MISO(miso4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer on the default instance; exp_seq is MOSI sampled at each SCLK rise.
  task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [1:0] mode,
                          input logic [7:0] exp_rx, input logic [7:0] exp_seq);
    int n, rises, first_rise;
    logic [7:0] seq;
    logic prev_sclk;
    bit seen;
    @(negedge clk);
    miso_mode = mode;
    tx_data   = tx;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    tx_data = ~tx;
    rises = 0; first_rise = -1; seq = '0; prev_sclk = 1'b0; seen = 1'b0;
    for (n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check_eq({tag, "_lead_csn"}, 32'(cs_n), 32'd0);
        check_eq({tag, "_lead_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_lead_mosi"}, 32'(mosi), 32'(exp_seq[7]));
      end
      if (sclk && !prev_sclk) begin
        if (rises == 0) first_rise = n;
        rises++;
        seq = {seq[6:0], mosi};
      end
      prev_sclk = sclk;
      if (done) begin
        seen = 1'b1;
        check_eq({tag, "_done_time"}, 32'(n), 32'd36);
        check_eq({tag, "_rx"}, 32'(rx_data), 32'(exp_rx));
        check_eq({tag, "_done_csn"}, 32'(cs_n), 32'd1);
        check_eq({tag, "_done_busy"}, 32'(busy), 32'd0);
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_rises"}, 32'(rises), 32'd8);
    check_eq({tag, "_first_rise"}, 32'(first_rise), 32'd2);
    check_eq({tag, "_mosi_seq"}, 32'(seq), 32'(exp_seq));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_rx_hold"}, 32'(rx_data), 32'(exp_rx));
  endtask

  initial begin
    int dones, first_done, second_done, falls, second_low, rises, first_rise, last_rise;
    logic prev, prev_cs;
    logic [3:0] seq4;
    bit seen;

    clr = 1'b1; start = 1'b0; start4 = 1'b0; tx_data = '0; tx4 = '0; miso_mode = 2'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_csn", 32'(cs_n), 32'd1);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rx", 32'(rx_data), 32'd0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

`ifdef SPI_LSB_FIRST_EN
    run_xfer("lpbk_a5", 8'hA5, 2'd0, 8'hA5, 8'hA5);
    run_xfer("miso_one", 8'h00, 2'd1, 8'hFF, 8'h00);
    run_xfer("miso_z", 8'h3C, 2'd2, 8'h00, 8'h3C);
    run_xfer("lpbk_01", 8'h01, 2'd0, 8'h01, 8'h80);
`else
    run_xfer("lpbk_a5", 8'hA5, 2'd0, 8'hA5, 8'hA5);
    run_xfer("miso_one", 8'h00, 2'd1, 8'hFF, 8'h00);
    run_xfer("miso_z", 8'h3C, 2'd2, 8'h00, 8'h3C);
    run_xfer("lpbk_01", 8'h01, 2'd0, 8'h01, 8'h01);
`endif

    // start held high: back-to-back transfers, nothing queued while busy
    @(negedge clk);
    miso_mode = 2'd0; tx_data = 8'h5A; start = 1'b1;
    @(posedge clk);
    dones = 0; first_done = -1; second_done = -1; falls = 0; second_low = -1; prev_cs = 1'b0;
    for (int m = 0; m < 100; m++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (first_done < 0) first_done = m;
        else second_done = m;
      end
      if (!cs_n && prev_cs) begin
        falls++;
        second_low = m;
      end
      prev_cs = cs_n;
      if (m == 59) start = 1'b0;
    end
    check_eq("hold_dones", 32'(dones), 32'd2);
    check_eq("hold_first_done", 32'(first_done), 32'd36);
    check_eq("hold_second_csn_low", 32'(second_low), 32'd38);
    check_eq("hold_second_done", 32'(second_done), 32'd74);
    check_eq("hold_csn_falls", 32'(falls), 32'd1);
    check_eq("hold_rx", 32'(rx_data), 32'h5A);

    // abort with CLR during bit 3
    @(negedge clk);
    tx_data = 8'hC3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 40 && rises < 4; n++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    check_eq("abort_reached_bit3", 32'(rises), 32'd4);
    clr = 1'b1;
    @(negedge clk);
    check_eq("abort_csn", 32'(cs_n), 32'd1);
    check_eq("abort_sclk", 32'(sclk), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_rx", 32'(rx_data), 32'd0);
    clr = 1'b0;
    dones = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done || !cs_n) dones++;
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);

    // narrow instance: DATA_W=4, CLK_DIV=1
    @(negedge clk);
    tx4 = 4'hA; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    rises = 0; first_rise = -1; last_rise = -1; prev = 1'b0; seq4 = '0; seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (sclk4 && !prev) begin
        if (rises == 0) first_rise = n;
        last_rise = n;
        rises++;
        seq4 = {seq4[2:0], mosi4};
      end
      prev = sclk4;
      if (done4) begin
        seen = 1'b1;
        check_eq("w4_done_time", 32'(n), 32'd10);
        check_eq("w4_rx", 32'(rx4), 32'hA);
      end
    end
    check_eq("w4_done_seen", 32'(seen), 32'd1);
    check_eq("w4_rises", 32'(rises), 32'd4);
    check_eq("w4_first_rise", 32'(first_rise), 32'd1);
    check_eq("w4_last_rise", 32'(last_rise), 32'd7);
`ifdef SPI_LSB_FIRST_EN
    check_eq("w4_mosi_seq", 32'(seq4), 32'h5);
`else
    check_eq("w4_mosi_seq", 32'(seq4), 32'hA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Sequencing controller for the SPI interface's shift datapath: accepts a parallel word from the host, drives CS_N/SCLK/MOSI for one mode-0 (CPOL=0, CPHA=0) transfer, captures MISO into a receive shift register and reports completion. Sits between the host-side register interface and the SPI pins. Owns the transfer FSM, the SCLK divider and the bit counter.

## Interface
- DATA_W, 8, bits per transfer (≥2)
- CLK_DIV, 2, SCLK half-period in CLK cycles (≥1)
- CLK  input  1  system clock; all logic on posedge
- CLR  input  1  reset, asynchronous, active-high
- start  input  1  request transfer; sampled only in IDLE
- tx_data  input  DATA_W  word to send; latched when start accepted
- busy  output  1  high from cycle after acceptance through last TRAIL cycle
- done  output  1  one-cycle pulse, transfer complete
- rx_data  output  DATA_W  received word; updated in done cycle, held until next done
- CS_N  output  1  chip select, active-low
- SCLK  output  1  serial clock, idle low
- MOSI  output  1  serial data out
- MISO  input  1  serial data in; X/Z sampled as 0

## Operation
- Reset (CLR=1, any time incl. mid-transfer): state IDLE, CS_N=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0, counters and shift registers 0. No done pulse for an aborted transfer.
- States: IDLE, LEAD, XFER, TRAIL, DONE.
- IDLE: start=1 → latch tx_data, go LEAD. start=0 → stay.
- LEAD: CS_N=0, SCLK=0, MOSI=first bit; CLK_DIV cycles, then XFER.
- XFER: DATA_W SCLK periods, each CLK_DIV cycles high then CLK_DIV low. MISO captured at CLK edge ending first high-phase cycle. MOSI advances to next bit on first low-phase cycle (falling SCLK). After bit DATA_W-1 low phase → TRAIL.
- TRAIL: CS_N=0, SCLK=0 for CLK_DIV cycles, then DONE.
- DONE: one cycle; CS_N=1, busy=0, done=1, rx_data=captured word. → IDLE.
- start while busy or in DONE: ignored, not queued. tx_data changes after acceptance: no effect.
- Bit counter width clog2(DATA_W); wraps only via FSM reset to 0 on acceptance.

## Timing
- Acceptance at edge t0 → LEAD begins t0+1 (CS_N low, MOSI valid).
- First SCLK rise at t0+1+CLK_DIV.
- done at t0+1+2·CLK_DIV+2·DATA_W·CLK_DIV; defaults: t0+37.
- Minimum CS_N high between transfers: 2 cycles (DONE + IDLE acceptance cycle).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SPI_LSB_FIRST_EN defined: bit 0 transmitted first; first received bit stored in rx_data[0].
- Undefined (default): MSB first on MOSI; first received bit stored in rx_data[DATA_W-1].
- Timing, states and handshake identical in both builds.

## Structure
- spi_ctrl_pkg: state enum typedef (IDLE, LEAD, XFER, TRAIL, DONE), SPI mode constants (CPOL=0, CPHA=0), default DATA_W/CLK_DIV constants.
- Sub-module spi_clk_div: half-period counter, input enable, outputs phase_tick every CLK_DIV cycles; reset by CLR and on acceptance.
- Shift registers, bit counter, FSM in spi_master_ctrl.

## Test plan
- Reset values: CLR pulse mid-XFER (bit 3) → next cycle CS_N=1, SCLK=0, busy=0, done=0, rx_data=0; no done afterwards.
- Loopback MISO=MOSI, tx_data=8'hA5, defaults → done at t0+37, rx_data=8'hA5, 8 SCLK rises, MOSI sequence 1,0,1,0,0,1,0,1.
- MISO tied 1, tx_data=8'h00 → rx_data=8'hFF; MISO Z → rx_data=8'h00.
- start held high for 60 cycles → exactly one transfer per acceptance, second CS_N low 2 cycles after first done, start during busy ignored.
- CLK_DIV=1, DATA_W=4 → done at t0+11, SCLK period 2 cycles.
- SPI_LSB_FIRST_EN, tx_data=8'h01, loopback → MOSI first bit 1, rx_data=8'h01.
